// File: rtl/sram_controller_if.sv
// ----------------------------------------------------------------------------
// sram_controller_if
// Pipeline-side bundle between the memory stage and sram_controller.
//   rd_en, wr_en : read / write request, held until ready
//   address      : 32-bit byte address (data region)
//   wdata        : 32-bit store value
//   rdata        : last completed read word
//   ready        : stage may advance (pipeline freeze is its inverse)
//   err          : sticky misalignment flag
// modport master : memory stage side
// modport slave  : controller side
// ----------------------------------------------------------------------------
interface sram_controller_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    modport master (
        output rd_en, wr_en, address, wdata,
        input  rdata, ready, err
    );

    modport slave (
        input  rd_en, wr_en, address, wdata,
        output rdata, ready, err
    );
endinterface

// File: rtl/sram_controller.sv
// ----------------------------------------------------------------------------
// sram_controller
// Splits one 32-bit pipeline read/write into two 16-bit accesses to an
// external asynchronous SRAM. ready is held low until the access completes.
//
// Parameters
//   ADDR_W      : SRAM half-word address width (default 18)
//   WAIT_CYCLES : cycles per half-word phase, 2..15 (default 3)
//
// Ports
//   clk, rst    : clock, asynchronous active-high reset
//   bus         : sram_controller_if.slave pipeline handshake
//   sram_addr   : half-word address {address[ADDR_W:2], half}
//   sram_dq_o   : write data to SRAM
//   sram_dq_i   : read data from SRAM
//   sram_dq_oe  : data bus output enable
//   sram_we_n   : write strobe, active-low
//
// Build option
//   SRAM_ALIGN_CHK_EN : when defined, a request with address[1:0] != 0 skips
//                       the SRAM phases and sets the sticky err flag.
// ----------------------------------------------------------------------------
module sram_controller #(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    sram_controller_if.slave  bus,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_o,
    input  logic [15:0]       sram_dq_i,
    output logic              sram_dq_oe,
    output logic              sram_we_n
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RD_LO = 3'd1;
    localparam logic [2:0] RD_HI = 3'd2;
    localparam logic [2:0] WR_LO = 3'd3;
    localparam logic [2:0] WR_HI = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    logic [2:0]  state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] rdata_reg;
    logic        last_cycle;
    logic        phase_hi;
    logic        wr_phase;
    logic        misaligned;

    assign last_cycle = (cnt_reg == LAST_CNT);
    assign phase_hi   = (state_reg == RD_HI) || (state_reg == WR_HI);
    assign wr_phase   = (state_reg == WR_LO) || (state_reg == WR_HI);

`ifdef SRAM_ALIGN_CHK_EN
    logic err_reg;
    assign misaligned = (bus.address[1:0] != 2'b00);
    assign bus.err    = err_reg;
`else
    assign misaligned = 1'b0;
    assign bus.err    = 1'b0;
`endif

    // Upper address bits lie outside the SRAM; the low two bits only matter
    // for the alignment check.
    logic unused_addr;
    assign unused_addr = ^{bus.address[31:ADDR_W+1], bus.address[1:0]};

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = 4'd0;
                if (bus.wr_en || bus.rd_en) begin
                    if (misaligned)
                        state_next = DONE;
                    else if (bus.wr_en)
                        state_next = WR_LO;
                    else
                        state_next = RD_LO;
                end
            end
            RD_LO, RD_HI, WR_LO, WR_HI: begin
                if (last_cycle) begin
                    cnt_next = 4'd0;
                    case (state_reg)
                        RD_LO:   state_next = RD_HI;
                        WR_LO:   state_next = WR_HI;
                        default: state_next = DONE;
                    endcase
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            DONE: begin
                cnt_next   = 4'd0;
                state_next = IDLE;
            end
            default: begin
                cnt_next   = 4'd0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            rdata_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            // Sample the SRAM at the end of each read phase, after the full
            // access time has elapsed.
            if (state_reg == RD_LO && last_cycle)
                rdata_reg[15:0] <= sram_dq_i;
            if (state_reg == RD_HI && last_cycle)
                rdata_reg[31:16] <= sram_dq_i;
        end
    end

`ifdef SRAM_ALIGN_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_reg <= 1'b0;
        else if (state_reg == IDLE && (bus.rd_en || bus.wr_en) && misaligned)
            err_reg <= 1'b1;
    end
`endif

    assign bus.rdata = rdata_reg;
    assign bus.ready = (state_reg == DONE) ||
                       (state_reg == IDLE && !bus.rd_en && !bus.wr_en);

    assign sram_addr = {bus.address[ADDR_W:2], phase_hi};

    // The strobe is released in the last cycle of each phase so data and
    // address stay valid past the rising edge of we_n (hold time).
    always_comb begin
        sram_dq_oe = 1'b0;
        sram_we_n  = 1'b1;
        sram_dq_o  = 16'd0;
        if (wr_phase) begin
            sram_dq_oe = 1'b1;
            sram_we_n  = last_cycle;
            sram_dq_o  = phase_hi ? bus.wdata[31:16] : bus.wdata[15:0];
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;
    localparam int ADDR_W = 18;
    localparam int WAIT   = 3;
    localparam int LAT    = 1 + 2 * WAIT;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] sram_addr;
    logic [15:0]       sram_dq_o;
    logic [15:0]       sram_dq_i;
    logic              sram_dq_oe;
    logic              sram_we_n;

    sram_controller_if bus ();

    sram_controller #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .sram_addr  (sram_addr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM model (low 8 address bits are enough here).
    logic [15:0] sram_mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) sram_mem[i] = 16'd0;
        sram_mem[8'h08] = 16'hBEEF;
        sram_mem[8'h09] = 16'hDEAD;
    end
    always @(posedge clk) begin
        if (!sram_we_n) sram_mem[sram_addr[7:0]] <= sram_dq_o;
    end
    assign sram_dq_i = sram_mem[sram_addr[7:0]];

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp_word [logic [31:0]];
    logic [31:0] last_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one request (inputs already at posedge+1), waits for ready,
    // checks latency and the scoreboarded rdata, and returns at the posedge+1
    // following the DONE cycle with the request still applied.
    task automatic run_txn(input string tag, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d,
                           input int exp_lat, input logic chk_strobes);
        int lat;
        int ph;
        int pos;
        logic [31:0] exp_rd;
        logic [31:0] wa;
        bus.rd_en   = r;
        bus.wr_en   = w;
        bus.address = a;
        bus.wdata   = d;
        wa = {a[31:2], 2'b00};
        if (w && exp_lat == LAT) exp_word[wa] = d;
        else if (r && !w && exp_lat == LAT) last_rd = exp_word.exists(wa) ? exp_word[wa] : 32'd0;
        exp_q.push_back(last_rd);
        lat = 0;
        forever begin
            @(negedge clk);
            if (chk_strobes && lat >= 1 && lat <= 2 * WAIT) begin
                ph  = (lat - 1) / WAIT;
                pos = (lat - 1) % WAIT;
                check({tag, "_we_n"}, {31'd0, sram_we_n}, {31'd0, pos == WAIT - 1});
                check({tag, "_oe"}, {31'd0, sram_dq_oe}, 32'd1);
                check({tag, "_addr"}, 32'(sram_addr), 32'(wa[ADDR_W:2]) * 2 + 32'(ph));
                check({tag, "_dq"}, {16'd0, sram_dq_o}, {16'd0, (ph == 1) ? d[31:16] : d[15:0]});
            end
            if (bus.ready) break;
            lat++;
            if (lat > 60) begin
                check({tag, "_timeout"}, 32'(lat), 32'(exp_lat));
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        exp_rd = exp_q.pop_front();
        check({tag, "_rdata"}, bus.rdata, exp_rd);
        $display("txn %s rd=%0b wr=%0b addr=%h wdata=%h lat=%0d rdata=%h err=%0b",
                 tag, r, w, a, d, lat, bus.rdata, bus.err);
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int misal_lat;
        bus.rd_en   = 1'b0;
        bus.wr_en   = 1'b0;
        bus.address = 32'd0;
        bus.wdata   = 32'd0;
        last_rd     = 32'd0;
        exp_word[32'h10] = 32'hDEADBEEF;

        // Reset with no requests
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, bus.ready}, 32'd1);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_err", {31'd0, bus.err}, 32'd0);
        check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        check("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
        check("rst_dq", {16'd0, sram_dq_o}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Read of 0x10 -> 0xDEADBEEF
        run_txn("rd10", 1'b1, 1'b0, 32'h10, 32'd0, LAT, 1'b0);
        go_idle();

        // Write with full strobe checks
        run_txn("wr20", 1'b0, 1'b1, 32'h20, 32'h12345678, LAT, 1'b1);
        go_idle();

        // Both requests high: write wins, rdata unchanged
        run_txn("both30", 1'b1, 1'b1, 32'h30, 32'hCAFEF00D, LAT, 1'b1);
        go_idle();

        // Back-to-back write then read of the same address; the next request
        // is already applied in the cycle after DONE, so ready must be low there.
        run_txn("b2b_wr", 1'b0, 1'b1, 32'h24, 32'hA5A55A5A, LAT, 1'b0);
        run_txn("b2b_rd", 1'b1, 1'b0, 32'h24, 32'd0, LAT, 1'b0);
        run_txn("rd20", 1'b1, 1'b0, 32'h20, 32'd0, LAT, 1'b0);
        run_txn("rd30", 1'b1, 1'b0, 32'h30, 32'd0, LAT, 1'b0);
        go_idle();

        // Reset asserted during WR_HI
        bus.wr_en   = 1'b1;
        bus.address = 32'h40;
        bus.wdata   = 32'h11112222;
        repeat (1 + WAIT + 1) @(negedge clk);
        check("mid_we_low", {31'd0, sram_we_n}, 32'd0);
        check("mid_addr_hi", 32'(sram_addr), 32'h21);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_we_n", {31'd0, sram_we_n}, 32'd1);
        check("mid_rst_oe", {31'd0, sram_dq_oe}, 32'd0);
        check("mid_rst_rdata", bus.rdata, 32'd0);
        bus.wr_en = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, bus.ready}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        last_rd = 32'd0;
        @(posedge clk);
        #1;

`ifdef SRAM_ALIGN_CHK_EN
        misal_lat = 1;
`else
        misal_lat = LAT;
        exp_word[32'h10] = 32'hDEADBEEF;
`endif
        // Misaligned read at 0x13
        bus.rd_en   = 1'b1;
        bus.address = 32'h13;
        @(negedge clk);
        check("mis_we_n_c0", {31'd0, sram_we_n}, 32'd1);
        @(posedge clk);
        #1;
        bus.rd_en = 1'b0;
        go_idle();
        // Re-run through the scoreboarded path (rst clears any leftover state)
        rst = 1'b1;
        #1 rst = 1'b0;
        last_rd = 32'd0;
        @(posedge clk);
        #1;
        run_txn("mis13", 1'b1, 1'b0, 32'h13, 32'd0, misal_lat, 1'b0);
        go_idle();
`ifdef SRAM_ALIGN_CHK_EN
        check("mis_err", {31'd0, bus.err}, 32'd1);
        run_txn("after_mis", 1'b1, 1'b0, 32'h10, 32'd0, LAT, 1'b0);
        go_idle();
        check("err_sticky", {31'd0, bus.err}, 32'd1);
`else
        check("err_tied0", {31'd0, bus.err}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
